// File: rtl/piece_move_controller.sv
// Move sequencer for the falling tetromino: latches requests and gravity, issues one
// candidate at a time to the collision checker, then commits, discards or locks.
module piece_move_controller #(
  parameter int GRAV_PERIOD = 25000000,
  parameter int CHECK_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spawn,
  input  logic [2:0] spawn_shape,
  input  logic [3:0] spawn_x,
  input  logic [4:0] spawn_y,
  input  logic       req_rot,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_down,
  input  logic       chk_valid,
  input  logic [3:0] chk_colmask,
  output logic [3:0] chk_x,
  output logic [4:0] chk_y,
  output logic [2:0] chk_shape,
  output logic [1:0] chk_rot,
  output logic [3:0] cur_x,
  output logic [4:0] cur_y,
  output logic [2:0] cur_shape,
  output logic [1:0] cur_rot,
  output logic       active,
  output logic       moved,
  output logic       lock,
  output logic       game_over
);

  localparam int GW = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;
  localparam int LW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SP_ISSUE, S_SP_EVAL, S_READY, S_ISSUE, S_EVAL, S_LOCK, S_OVER
  } state_t;

  typedef enum logic [2:0] {
    K_ROT, K_LEFT, K_RIGHT, K_DOWN, K_GRAV
  } kind_t;

  state_t        r_state;
  kind_t         r_kind;
  logic [3:0]    r_chk_x, r_cur_x;
  logic [4:0]    r_chk_y, r_cur_y;
  logic [2:0]    r_chk_shape, r_cur_shape;
  logic [1:0]    r_chk_rot, r_cur_rot;
  logic          r_active, r_moved, r_lock, r_game_over;
  logic [4:0]    r_pend;
  logic [GW-1:0] r_grav_cnt;
  logic [LW-1:0] r_lat;

  logic          w_active_st;
  logic          w_grav_tick;
  logic [4:0]    w_grant;
  logic [4:0]    w_pend_next;
  logic [3:0]    w_col_ok;
  logic          w_range_ok;
  logic          w_legal;
  logic          w_lat_done;
  kind_t         w_kind;
  logic [3:0]    w_cand_x;
  logic [4:0]    w_cand_y;
  logic [1:0]    w_cand_rot;

  assign w_active_st = (r_state == S_READY) || (r_state == S_ISSUE) || (r_state == S_EVAL);
  assign w_grav_tick = w_active_st && (r_grav_cnt == GW'(GRAV_PERIOD - 1));
  assign w_lat_done  = (r_lat == LW'(CHECK_LAT - 1));

  // Every occupied pattern column must land on a playfield column (3..12).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [4:0] w_sum;
      assign w_sum        = {1'b0, r_chk_x} + 5'(gi);
      assign w_col_ok[gi] = !chk_colmask[gi] || ((w_sum >= 5'd3) && (w_sum <= 5'd12));
    end
  endgenerate

  assign w_range_ok = &w_col_ok;
  assign w_legal    = chk_valid && w_range_ok;

  // Lowest set bit wins: rot > left > right > down > gravity.
  assign w_grant = r_pend & (~r_pend + 5'd1);

  always_comb begin
    w_kind     = K_GRAV;
    w_cand_x   = r_cur_x;
    w_cand_y   = r_cur_y - 5'd1;
    w_cand_rot = r_cur_rot;
    if (r_pend[0]) begin
      w_kind     = K_ROT;
      w_cand_y   = r_cur_y;
      w_cand_rot = r_cur_rot + 2'd1;
    end else if (r_pend[1]) begin
      w_kind   = K_LEFT;
      w_cand_y = r_cur_y;
      w_cand_x = r_cur_x - 4'd1;
    end else if (r_pend[2]) begin
      w_kind   = K_RIGHT;
      w_cand_y = r_cur_y;
      w_cand_x = r_cur_x + 4'd1;
    end else if (r_pend[3]) begin
      w_kind = K_DOWN;
    end
  end

  always_comb begin
    w_pend_next = r_pend;
    if (r_state == S_LOCK) begin
      w_pend_next = '0;
    end else if ((r_state != S_IDLE) && (r_state != S_OVER)) begin
      if (r_state == S_READY) w_pend_next = w_pend_next & ~w_grant;
      w_pend_next = w_pend_next | {w_grav_tick, req_down, req_right, req_left, req_rot};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_kind      <= K_ROT;
      r_chk_x     <= '0;
      r_chk_y     <= '0;
      r_chk_shape <= '0;
      r_chk_rot   <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_cur_shape <= '0;
      r_cur_rot   <= '0;
      r_active    <= 1'b0;
      r_moved     <= 1'b0;
      r_lock      <= 1'b0;
      r_game_over <= 1'b0;
      r_pend      <= '0;
      r_grav_cnt  <= '0;
      r_lat       <= '0;
    end else begin
      r_moved <= 1'b0;
      r_lock  <= 1'b0;
      r_pend  <= w_pend_next;
      if (w_active_st) r_grav_cnt <= w_grav_tick ? '0 : r_grav_cnt + GW'(1);

      unique case (r_state)
        S_IDLE: begin
          if (spawn) begin
            r_chk_x     <= spawn_x;
            r_chk_y     <= spawn_y;
            r_chk_shape <= spawn_shape;
            r_chk_rot   <= 2'd0;
            r_lat       <= '0;
            r_state     <= S_SP_ISSUE;
          end
        end
        S_SP_ISSUE: begin
          if (w_lat_done) r_state <= S_SP_EVAL;
          else            r_lat   <= r_lat + LW'(1);
        end
        S_SP_EVAL: begin
          if (w_legal) begin
            r_cur_x     <= r_chk_x;
            r_cur_y     <= r_chk_y;
            r_cur_shape <= r_chk_shape;
            r_cur_rot   <= r_chk_rot;
            r_moved     <= 1'b1;
            r_active    <= 1'b1;
            r_grav_cnt  <= '0;
            r_state     <= S_READY;
          end else begin
            r_chk_x     <= r_cur_x;
            r_chk_y     <= r_cur_y;
            r_chk_shape <= r_cur_shape;
            r_chk_rot   <= r_cur_rot;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end
        end
        S_READY: begin
          if (|r_pend) begin
            r_kind    <= w_kind;
            r_chk_x   <= w_cand_x;
            r_chk_y   <= w_cand_y;
            r_chk_rot <= w_cand_rot;
            r_lat     <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_lat_done) r_state <= S_EVAL;
          else            r_lat   <= r_lat + LW'(1);
        end
        S_EVAL: begin
          if (w_legal) begin
            r_cur_x   <= r_chk_x;
            r_cur_y   <= r_chk_y;
            r_cur_rot <= r_chk_rot;
            r_moved   <= 1'b1;
            if (r_kind == K_DOWN) r_grav_cnt <= '0;
            r_state   <= S_READY;
          end else begin
            // A rejected candidate is dropped; chk_* go back to tracking cur_*.
            r_chk_x   <= r_cur_x;
            r_chk_y   <= r_cur_y;
            r_chk_rot <= r_cur_rot;
            if ((r_kind == K_DOWN) || (r_kind == K_GRAV)) begin
              r_lock   <= 1'b1;
              r_active <= 1'b0;
              r_state  <= S_LOCK;
            end else begin
              r_state <= S_READY;
            end
          end
        end
        S_LOCK: begin
          r_state <= S_IDLE;
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign chk_x     = r_chk_x;
  assign chk_y     = r_chk_y;
  assign chk_shape = r_chk_shape;
  assign chk_rot   = r_chk_rot;
  assign cur_x     = r_cur_x;
  assign cur_y     = r_cur_y;
  assign cur_shape = r_cur_shape;
  assign cur_rot   = r_cur_rot;
  assign active    = r_active;
  assign moved     = r_moved;
  assign lock      = r_lock;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_piece_move_controller.sv
// Scoreboard bench: a behavioural board/checker model predicts moved/lock/game_over
// events in order; a negedge monitor pops and compares each event the DUT emits.
module tb_piece_move_controller;

  localparam int GP = 300;
  localparam int CL = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spawn;
  logic [2:0] spawn_shape;
  logic [3:0] spawn_x;
  logic [4:0] spawn_y;
  logic       req_rot, req_left, req_right, req_down;
  logic       chk_valid;
  logic [3:0] chk_colmask;
  logic [3:0] chk_x, cur_x;
  logic [4:0] chk_y, cur_y;
  logic [2:0] chk_shape, cur_shape;
  logic [1:0] chk_rot, cur_rot;
  logic       active, moved, lock, game_over;

  logic force_inv;
  logic board_en;

  always #5 clk = ~clk;

  piece_move_controller #(.GRAV_PERIOD(GP), .CHECK_LAT(CL)) dut (
    .clk(clk), .rst_n(rst_n), .spawn(spawn), .spawn_shape(spawn_shape),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .req_rot(req_rot), .req_left(req_left),
    .req_right(req_right), .req_down(req_down), .chk_valid(chk_valid),
    .chk_colmask(chk_colmask), .chk_x(chk_x), .chk_y(chk_y), .chk_shape(chk_shape),
    .chk_rot(chk_rot), .cur_x(cur_x), .cur_y(cur_y), .cur_shape(cur_shape),
    .cur_rot(cur_rot), .active(active), .moved(moved), .lock(lock), .game_over(game_over)
  );

  // Pattern ROM stand-in: occupied columns depend on shape and rotation.
  function automatic logic [3:0] mask_fn(input logic [2:0] s, input logic [1:0] r);
    logic [2:0] i;
    i = s + 3'(r);
    case (i)
      3'd0: return 4'b0011;
      3'd1: return 4'b0110;
      3'd2: return 4'b1100;
      3'd3: return 4'b0111;
      3'd4: return 4'b0001;
      3'd5: return 4'b1110;
      3'd6: return 4'b0010;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic valid_fn(input int x, input int y, input int r,
                                    input logic finv, input logic ben);
    if (finv) return 1'b0;
    if (y > 25) return 1'b0;
    if (ben && (((x * 5 + y * 3 + r) % 7) == 0)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic range_fn(input logic [3:0] m, input int x);
    for (int j = 0; j < 4; j++)
      if (m[j] && ((x + j < 3) || (x + j > 12))) return 1'b0;
    return 1'b1;
  endfunction

  assign chk_valid   = valid_fn(int'(chk_x), int'(chk_y), int'(chk_rot), force_inv, board_en);
  assign chk_colmask = mask_fn(chk_shape, chk_rot);

  typedef struct {
    int kind;
    int x;
    int y;
    int s;
    int r;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_x, m_y, m_s, m_r;
  bit   m_active;
  logic go_prev;

  function automatic logic [31:0] pk(input int k, input int x, input int y, input int s, input int r);
    return {8'(k), 4'(x), 8'(y), 4'(s), 8'(r)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic legal_fn(input int x, input int y, input int s, input int r);
    return valid_fn(x, y, r, force_inv, board_en) && range_fn(mask_fn(3'(s), 2'(r)), x);
  endfunction

  task automatic push_exp(input int k, input int x, input int y, input int s, input int r);
    exp_t e;
    e.kind = k; e.x = x; e.y = y; e.s = s; e.r = r;
    q.push_back(e);
  endtask

  // Reference: kinds 0 rot, 1 left, 2 right, 3 soft drop, 4 gravity.
  task automatic model_req(input int k);
    int nx, ny, nr;
    nx = m_x; ny = m_y; nr = m_r;
    case (k)
      0: nr = (m_r + 1) % 4;
      1: nx = (m_x + 15) % 16;
      2: nx = (m_x + 1) % 16;
      default: ny = (m_y + 31) % 32;
    endcase
    if (legal_fn(nx, ny, m_s, nr)) begin
      m_x = nx; m_y = ny; m_r = nr;
      push_exp(1, m_x, m_y, m_s, m_r);
    end else if (k >= 3) begin
      m_active = 0;
      push_exp(2, m_x, m_y, m_s, m_r);
    end
  endtask

  task automatic model_spawn(input int s, input int x, input int y);
    if (legal_fn(x, y, s, 0)) begin
      m_x = x; m_y = y; m_s = s; m_r = 0; m_active = 1;
      push_exp(1, m_x, m_y, m_s, m_r);
    end else begin
      push_exp(3, m_x, m_y, m_s, m_r);
    end
  endtask

  task automatic mon_event(input int k);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event actual=kind%0d required=none", k);
    end else begin
      e = q.pop_front();
      check("event", pk(k, cur_x, cur_y, cur_shape, cur_rot), pk(e.kind, e.x, e.y, e.s, e.r));
      $display("EVT kind=%0d x=%0d y=%0d shape=%0d rot=%0d", k, cur_x, cur_y, cur_shape, cur_rot);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      go_prev = 1'b0;
    end else begin
      if (moved) mon_event(1);
      if (lock) begin
        mon_event(2);
        check("lock_inactive", 32'(active), 32'd0);
      end
      if (game_over && !go_prev) mon_event(3);
      go_prev = game_over;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] b);
    req_rot = b[0]; req_left = b[1]; req_right = b[2]; req_down = b[3];
    tick();
    req_rot = 0; req_left = 0; req_right = 0; req_down = 0;
  endtask

  task automatic do_spawn(input int s, input int x, input int y);
    spawn = 1; spawn_shape = 3'(s); spawn_x = 4'(x); spawn_y = 5'(y);
    tick();
    spawn = 0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) tick();
    check("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    q.delete();
    m_x = 0; m_y = 0; m_s = 0; m_r = 0; m_active = 0;
    rst_n = 1;
    tick();
  endtask

  task automatic check_cur(input string name);
    check(name, pk(0, cur_x, cur_y, cur_shape, cur_rot), pk(0, m_x, m_y, m_s, m_r));
    check({name, "_mirror"}, pk(0, chk_x, chk_y, chk_shape, chk_rot), pk(0, m_x, m_y, m_s, m_r));
    check({name, "_active"}, 32'(active), 32'(m_active));
  endtask

  initial begin
    int lat;
    int s, x, y;
    logic [3:0] bits;
    rst_n = 0; spawn = 0; spawn_shape = 0; spawn_x = 0; spawn_y = 0;
    req_rot = 0; req_left = 0; req_right = 0; req_down = 0;
    force_inv = 0; board_en = 0;
    go_prev = 0;
    do_reset();

    check("rst_cur", pk(0, cur_x, cur_y, cur_shape, cur_rot), 32'd0);
    check("rst_chk", pk(0, chk_x, chk_y, chk_shape, chk_rot), 32'd0);
    check("rst_flags", {28'd0, active, moved, lock, game_over}, 32'd0);

    // Spawn and commit latency.
    model_spawn(1, 7, 19);
    do_spawn(1, 7, 19);
    lat = 1;
    while (!moved && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("spawn_latency", 32'(lat), 32'd3);
    tick();
    check_cur("spawn");

    // Rotate and left together: rotation commits first.
    model_req(0);
    model_req(1);
    pulse_req(4'b0011);
    repeat (20) tick();
    wait_drain(10);
    check_cur("rot_left");

    // Soft drop to the floor until the piece locks.
    for (int i = 0; i < 25 && m_active; i++) begin
      model_req(3);
      pulse_req(4'b1000);
      repeat (8) tick();
    end
    wait_drain(20);
    tick();
    check_cur("soft_lock");

    // Horizontal range boundaries with a single-column pattern.
    model_spawn(4, 4, 0);
    do_spawn(4, 4, 0);
    repeat (6) tick();
    for (int i = 0; i < 2; i++) begin
      model_req(1);
      pulse_req(4'b0010);
      repeat (10) tick();
    end
    check_cur("left_edge");
    for (int i = 0; i < 10; i++) begin
      model_req(2);
      pulse_req(4'b0100);
      repeat (10) tick();
    end
    check_cur("right_edge");

    // Gravity at y=0 wraps the candidate to 31 and locks the piece.
    model_req(4);
    wait_drain(2 * GP + 50);
    tick();
    tick();
    check_cur("grav_lock");

    // Random pieces on an obstructed board.
    board_en = 1;
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 200; a++) begin
        s = $urandom_range(0, 7);
        x = $urandom_range(0, 15);
        y = $urandom_range(0, 6);
        if (legal_fn(x, y, s, 0)) break;
      end
      model_spawn(s, x, y);
      do_spawn(s, x, y);
      repeat (5) tick();
      if (!m_active) break;
      for (int b = 0; b < 6; b++) begin
        bits = 4'($urandom_range(1, 15));
        if (m_active) begin
          for (int k = 0; k < 4; k++)
            if (bits[k] && m_active) model_req(k);
          if ($urandom_range(0, 3) == 0) begin
            spawn = 1; spawn_shape = 3'($urandom_range(0, 7));
            spawn_x = 4'($urandom_range(0, 15)); spawn_y = 5'($urandom_range(0, 31));
          end
          pulse_req(bits);
          spawn = 0;
          repeat (19) tick();
        end
      end
      wait_drain(20);
      while (m_active) begin
        model_req(4);
        wait_drain(2 * GP + 50);
      end
      tick();
      tick();
      check_cur("rand_piece");
    end
    board_en = 0;

    // Reset while a spawn check is in flight: no pulses, back to reset state.
    do_reset();
    do_spawn(3, 6, 10);
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (4) tick();
    check_cur("midcheck_reset");

    // Spawn collision raises game over; everything afterwards is ignored.
    force_inv = 1;
    model_spawn(2, 5, 5);
    do_spawn(2, 5, 5);
    wait_drain(20);
    force_inv = 0;
    check("game_over_set", 32'(game_over), 32'd1);
    do_spawn(1, 7, 10);
    pulse_req(4'b1111);
    repeat (20) tick();
    check("game_over_hold", 32'(game_over), 32'd1);
    check_cur("over_ignore");
    do_reset();
    check("game_over_clear", 32'(game_over), 32'd0);
    check("final_queue", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
